set_mode_ctrl: RTL

Time/date setting controller for the clock-calendar. It sequences manual editing across the hour, minute, day, month and year counters using three debounced buttons (mode, up, down). It issues single-cycle inc_manual/dec_manual strobes to the selected counter, with auto-repeat while a button is held. It also gates auto counting, drives the display blink, and clamps the day whenever it exceeds the month length (dim).

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/btn_repeat.sv | 52 +++++
 rtl/set_mode_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state and field encodings for the clock-calendar set controller
package clock_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_DAY   = 3'd3,
        SET_MONTH = 3'd4,
        SET_YEAR  = 3'd5
    } state_t;

    localparam logic [4:0] FLD_NONE  = 5'b00000;
    localparam logic [4:0] FLD_HOUR  = 5'b00001;
    localparam logic [4:0] FLD_MIN   = 5'b00010;
    localparam logic [4:0] FLD_DAY   = 5'b00100;
    localparam logic [4:0] FLD_MONTH = 5'b01000;
    localparam logic [4:0] FLD_YEAR  = 5'b10000;

    function automatic logic [4:0] field_of(input state_t s);
        case (s)
            SET_HOUR:  return FLD_HOUR;
            SET_MIN:   return FLD_MIN;
            SET_DAY:   return FLD_DAY;
            SET_MONTH: return FLD_MONTH;
            SET_YEAR:  return FLD_YEAR;
            default:   return FLD_NONE;
        endcase
    endfunction

    function automatic state_t next_state_of(input state_t s);
        case (s)
            RUN:       return SET_HOUR;
            SET_HOUR:  return SET_MIN;
            SET_MIN:   return SET_DAY;
            SET_DAY:   return SET_MONTH;
            SET_MONTH: return SET_YEAR;
            default:   return RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button edge detect with hold-then-repeat strobe generation
module btn_repeat #(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic en,
    input  logic clr,
    output logic level_r,
    output logic press,
    output logic strobe
);

    localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    // Reloading below HOLD_LAST makes every later fire land REPEAT_CYC cycles apart.
    localparam logic [CW-1:0] RELOAD    = (HOLD_CYC >= REPEAT_CYC) ? CW'(HOLD_CYC - REPEAT_CYC) : '0;

    logic          level_p;
    logic [CW-1:0] cnt;
    logic          active;
    logic          fire;

    assign press  = level_r & ~level_p;
    assign active = en & ~clr & level_r;
    assign fire   = active & (press | (cnt == HOLD_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            level_p <= 1'b0;
            cnt     <= '0;
            strobe  <= 1'b0;
        end else begin
            level_r <= level;
            level_p <= level_r;
            strobe  <= fire;
            if (!active)
                cnt <= '0;
            else if (press)
                cnt <= CW'(1);
            else if (cnt == HOLD_LAST)
                cnt <= RELOAD;
            else if (cnt < HOLD_LAST)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/set_mode_ctrl.sv
// rtl/set_mode_ctrl.sv - time/date set-mode sequencer with auto-repeat, blink and day clamp
module set_mode_ctrl #(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000,
    parameter int BLINK_CYC  = 12_500_000,
    parameter int TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] dim,
    input  logic [4:0] day_value,
    output logic [4:0] inc_manual,
    output logic [4:0] dec_manual,
    output logic       auto_en,
    output logic       sec_clr,
    output logic [4:0] field_sel,
    output logic       blink,
    output logic       day_load,
    output logic [4:0] day_load_val
);

    import clock_pkg::*;

    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    state_t        state;
    state_t        state_nxt;
    logic          mode_r, mode_p, mode_press;
    logic          up_r, up_press, up_strobe;
    logic          dn_r, dn_press, dn_strobe;
    logic          in_set, any_press, time_up, blink_restart;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_r;
    logic [1:0]    load_hold;

    assign mode_press = mode_r & ~mode_p;
    assign in_set     = (state != RUN);
    assign any_press  = mode_press | up_press | dn_press;
    assign time_up    = in_set & ~any_press & tick_1hz & (to_cnt == TW'(TIMEOUT_S - 1));

    // Holding both buttons, or a mode press, parks both repeat counters at zero.
    btn_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_up (
        .clk(clk), .rst_n(rst_n), .level(btn_up), .en(in_set), .clr(dn_r | mode_press),
        .level_r(up_r), .press(up_press), .strobe(up_strobe)
    );

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_dn (
        .clk(clk), .rst_n(rst_n), .level(btn_down), .en(in_set), .clr(up_r | mode_press),
        .level_r(dn_r), .press(dn_press), .strobe(dn_strobe)
    );

    always_comb begin
        state_nxt = state;
        if (mode_press)
            state_nxt = next_state_of(state);
        else if (time_up)
            state_nxt = RUN;
    end

    assign blink_restart = (state_nxt != state) | up_strobe | dn_strobe | ~in_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= 1'b0;
            mode_p    <= 1'b0;
            state     <= RUN;
            sec_clr   <= 1'b0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            blink_r   <= 1'b0;
        end else begin
            mode_r  <= btn_mode;
            mode_p  <= mode_r;
            state   <= state_nxt;
            sec_clr <= (state == SET_MIN) && (state_nxt != SET_MIN);
            if (!in_set || any_press)
                to_cnt <= '0;
            else if (tick_1hz && to_cnt < TW'(TIMEOUT_S))
                to_cnt <= to_cnt + 1'b1;
            if (blink_restart) begin
                blink_cnt <= '0;
                blink_r   <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_CYC - 1)) begin
                blink_cnt <= '0;
                blink_r   <= ~blink_r;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // After a load request the day counter needs two cycles before day_value is trusted again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_load  <= 1'b0;
            load_hold <= '0;
        end else begin
            day_load <= 1'b0;
            if (load_hold != 2'd0) begin
                load_hold <= load_hold - 1'b1;
            end else if ({1'b0, day_value} > dim) begin
                day_load  <= 1'b1;
                load_hold <= 2'd2;
            end
        end
    end

    assign field_sel    = field_of(state);
    assign auto_en      = ~in_set;
    assign blink        = blink_r & in_set;
    assign inc_manual   = up_strobe ? field_sel : 5'b00000;
    assign dec_manual   = dn_strobe ? field_sel : 5'b00000;
    assign day_load_val = dim[4:0];

endmodule
